// File: rtl/rps_match_controller.sv
// Best-of-3 rock/paper/scissors match controller with an external judge.
// Define ROUND_TIMEOUT_EN to let a locked player win a round by forfeit.
module rps_match_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] p1_move,
    input  logic [2:0] p2_move,
    input  logic       p1_valid,
    input  logic       p2_valid,
    output logic       p1_ready,
    output logic       p2_ready,
    output logic [2:0] judge_p1,
    output logic [2:0] judge_p2,
    input  logic       judge_p1wins,
    input  logic       judge_p2wins,
    input  logic       judge_tied,
    output logic       round_done,
    output logic [1:0] round_winner,
    output logic [1:0] p1_score,
    output logic [1:0] p2_score,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic       bad_move
);

    typedef enum logic [2:0] {IDLE, COLLECT, JUDGE, RESULT, DONE} state_t;

    state_t state;
    logic   lock1, lock2;
    logic   oh1, oh2;
    logic   take1, take2;
    logic   next1, next2;
    logic   bad;
    logic   win1, win2;

    assign oh1 = (p1_move == 3'b001) || (p1_move == 3'b010) || (p1_move == 3'b100);
    assign oh2 = (p2_move == 3'b001) || (p2_move == 3'b010) || (p2_move == 3'b100);

    assign p1_ready = (state == COLLECT) && !lock1;
    assign p2_ready = (state == COLLECT) && !lock2;

    assign take1 = p1_valid && p1_ready && oh1;
    assign take2 = p2_valid && p2_ready && oh2;
    assign next1 = lock1 || take1;
    assign next2 = lock2 || take2;
    assign bad   = (p1_valid && p1_ready && !oh1) || (p2_valid && p2_ready && !oh2);

    // Anything other than exactly one asserted judge input is a tie
    assign win1 = judge_p1wins && !judge_p2wins && !judge_tied;
    assign win2 = judge_p2wins && !judge_p1wins && !judge_tied;

`ifdef ROUND_TIMEOUT_EN
    logic [7:0] tmo;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            lock1        <= 1'b0;
            lock2        <= 1'b0;
            judge_p1     <= 3'b000;
            judge_p2     <= 3'b000;
            round_done   <= 1'b0;
            round_winner <= 2'b00;
            p1_score     <= 2'b00;
            p2_score     <= 2'b00;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
            bad_move     <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
            tmo          <= 8'd0;
`endif
        end else begin
            round_done   <= 1'b0;
            round_winner <= 2'b00;
            bad_move     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        p1_score <= 2'b00;
                        p2_score <= 2'b00;
                    end
                end
                COLLECT: begin
                    bad_move <= bad;
                    if (take1) begin
                        lock1    <= 1'b1;
                        judge_p1 <= p1_move;
                    end
                    if (take2) begin
                        lock2    <= 1'b1;
                        judge_p2 <= p2_move;
                    end
                    if (next1 && next2) begin
                        state <= JUDGE;
`ifdef ROUND_TIMEOUT_EN
                    end else if (!lock1 && !lock2) begin
                        tmo <= 8'd0;
                    end else if (tmo == 8'd254) begin
                        // The waiting player forfeits; skip the judge
                        state        <= RESULT;
                        round_done   <= 1'b1;
                        round_winner <= lock1 ? 2'b01 : 2'b10;
                        if (lock1) p1_score <= p1_score + 2'd1;
                        else       p2_score <= p2_score + 2'd1;
                    end else begin
                        tmo <= tmo + 8'd1;
`endif
                    end
                end
                JUDGE: begin
                    state        <= RESULT;
                    round_done   <= 1'b1;
                    round_winner <= {!win1, !win2};
                    if (win1) p1_score <= p1_score + 2'd1;
                    if (win2) p2_score <= p2_score + 2'd1;
                end
                RESULT: begin
                    lock1    <= 1'b0;
                    lock2    <= 1'b0;
                    judge_p1 <= 3'b000;
                    judge_p2 <= 3'b000;
                    if (p1_score == 2'd2 || p2_score == 2'd2) begin
                        state        <= DONE;
                        match_done   <= 1'b1;
                        match_winner <= (p1_score == 2'd2) ? 2'b01 : 2'b10;
                    end else begin
                        state <= COLLECT;
                    end
                end
                DONE: begin
                    if (start) begin
                        state        <= COLLECT;
                        p1_score     <= 2'b00;
                        p2_score     <= 2'b00;
                        match_done   <= 1'b0;
                        match_winner <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: vector table of rounds
// plus hand-written sequences for staggered, bad-move, reset and idle cases.
module tb_rps_match_controller;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [2:0] p1_move, p2_move;
    logic       p1_valid, p2_valid;
    logic       p1_ready, p2_ready;
    logic [2:0] judge_p1, judge_p2;
    logic       judge_p1wins, judge_p2wins, judge_tied;
    logic       round_done;
    logic [1:0] round_winner;
    logic [1:0] p1_score, p2_score;
    logic       match_done;
    logic [1:0] match_winner;
    logic       bad_move;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    rps_match_controller dut (
        .clock(clock), .reset(reset), .start(start),
        .p1_move(p1_move), .p2_move(p2_move),
        .p1_valid(p1_valid), .p2_valid(p2_valid),
        .p1_ready(p1_ready), .p2_ready(p2_ready),
        .judge_p1(judge_p1), .judge_p2(judge_p2),
        .judge_p1wins(judge_p1wins), .judge_p2wins(judge_p2wins),
        .judge_tied(judge_tied),
        .round_done(round_done), .round_winner(round_winner),
        .p1_score(p1_score), .p2_score(p2_score),
        .match_done(match_done), .match_winner(match_winner),
        .bad_move(bad_move)
    );

    typedef struct {
        logic       st;
        logic [2:0] m1, m2, j;
        logic [1:0] w, s1, s2;
        logic       md;
        logic [1:0] mw;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    // j = {p1wins, p2wins, tied}; returns at the negedge inside RESULT
    task automatic play(input logic [2:0] m1, input logic [2:0] m2,
                        input logic [2:0] j, input int gap, output logic [1:0] w);
        int n;
        {judge_p1wins, judge_p2wins, judge_tied} = j;
        @(posedge clock); #1;
        p1_move = m1; p1_valid = 1'b1;
        if (gap == 0) begin p2_move = m2; p2_valid = 1'b1; end
        @(posedge clock); #1;
        p1_valid = 1'b0; p2_valid = 1'b0;
        if (gap > 0) begin
            chk("p1_ready_after_lock", {7'd0, p1_ready}, 8'd0);
            chk("p2_ready_waiting", {7'd0, p2_ready}, 8'd1);
            repeat (gap - 1) @(posedge clock);
            #1 p2_move = m2; p2_valid = 1'b1;
            @(posedge clock); #1 p2_valid = 1'b0;
        end
        for (n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (round_done) break;
        end
        chk("round_latency", n[7:0], 8'd2);
        chk("judge_p1_held", {5'd0, judge_p1}, {5'd0, m1});
        chk("judge_p2_held", {5'd0, judge_p2}, {5'd0, m2});
        w = round_winner;
    endtask

    initial begin
        logic [1:0] w;
        int seen;

        v[0] = '{1'b1, 3'b001, 3'b100, 3'b100, 2'b01, 2'd1, 2'd0, 1'b0, 2'b00};
        v[1] = '{1'b0, 3'b010, 3'b010, 3'b001, 2'b11, 2'd1, 2'd0, 1'b0, 2'b00};
        v[2] = '{1'b0, 3'b010, 3'b010, 3'b110, 2'b11, 2'd1, 2'd0, 1'b0, 2'b00};
        v[3] = '{1'b0, 3'b100, 3'b001, 3'b010, 2'b10, 2'd1, 2'd1, 1'b0, 2'b00};
        v[4] = '{1'b0, 3'b001, 3'b010, 3'b010, 2'b10, 2'd1, 2'd2, 1'b1, 2'b10};
        v[5] = '{1'b1, 3'b010, 3'b001, 3'b100, 2'b01, 2'd1, 2'd0, 1'b0, 2'b00};
        v[6] = '{1'b0, 3'b100, 3'b100, 3'b000, 2'b11, 2'd1, 2'd0, 1'b0, 2'b00};
        v[7] = '{1'b0, 3'b100, 3'b010, 3'b100, 2'b01, 2'd2, 2'd0, 1'b1, 2'b01};

        reset = 1'b1; start = 1'b0;
        p1_move = 3'b000; p2_move = 3'b000;
        p1_valid = 1'b0; p2_valid = 1'b0;
        judge_p1wins = 1'b0; judge_p2wins = 1'b0; judge_tied = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", {6'd0, p1_ready, p2_ready}, 8'd0);
        chk("rst_scores", {4'd0, p1_score, p2_score}, 8'd0);
        chk("rst_match", {5'd0, match_done, match_winner}, 8'd0);
        chk("rst_round", {4'd0, bad_move, round_done, round_winner}, 8'd0);
        chk("rst_judge", {2'd0, judge_p1, judge_p2}, 8'd0);

        for (int i = 0; i < 8; i++) begin
            if (v[i].st) do_start();
            play(v[i].m1, v[i].m2, v[i].j, 0, w);
            chk($sformatf("v%0d_winner", i), {6'd0, w}, {6'd0, v[i].w});
            chk($sformatf("v%0d_scores", i), {4'd0, p1_score, p2_score},
                {4'd0, v[i].s1, v[i].s2});
            @(posedge clock); #1;
            chk($sformatf("v%0d_round_off", i), {7'd0, round_done}, 8'd0);
            chk($sformatf("v%0d_match", i), {5'd0, match_done, match_winner},
                {5'd0, v[i].md, v[i].mw});
            chk($sformatf("v%0d_ready", i), {7'd0, p1_ready}, {7'd0, !v[i].md});
        end

        do_start();
        chk("restart_clears", {4'd0, p1_score, p2_score}, 8'd0);
        for (int r = 0; r < 2; r++) begin
            play(3'b010, 3'b001, 3'b100, 3, w);
            chk("stagger_winner", {6'd0, w}, 8'd1);
        end
        @(posedge clock); #1;
        chk("stagger_match", {5'd0, match_done, match_winner}, 8'b101);
        chk("stagger_scores", {4'd0, p1_score, p2_score}, 8'b1000);

        do_start();
        @(posedge clock); #1 p1_move = 3'b011; p1_valid = 1'b1;
        @(posedge clock); #1 p1_valid = 1'b0;
        chk("bad_pulse", {7'd0, bad_move}, 8'd1);
        chk("bad_ready", {7'd0, p1_ready}, 8'd1);
        @(posedge clock); #1;
        chk("bad_one_cycle", {7'd0, bad_move}, 8'd0);
        play(3'b100, 3'b010, 3'b100, 0, w);
        chk("bad_then_ok", {6'd0, w}, 8'd1);
        chk("bad_then_score", {4'd0, p1_score, p2_score}, 8'b0100);

        @(posedge clock); #1;
        p1_move = 3'b001; p2_move = 3'b010; p1_valid = 1'b1; p2_valid = 1'b1;
        @(posedge clock); #1;
        p1_valid = 1'b0; p2_valid = 1'b0; reset = 1'b1; start = 1'b1;
        @(posedge clock); #1 reset = 1'b0; start = 1'b0;
        chk("rj_scores", {4'd0, p1_score, p2_score}, 8'd0);
        chk("rj_judge", {2'd0, judge_p1, judge_p2}, 8'd0);
        chk("rj_round", {5'd0, round_done, round_winner}, 8'd0);
        repeat (2) @(posedge clock);
        #1 chk("rj_idle", {6'd0, p1_ready, p2_ready}, 8'd0);

        do_start();
        play(3'b001, 3'b100, 3'b100, 0, w);
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        chk("sr_scores", {4'd0, p1_score, p2_score}, 8'b0100);
        chk("sr_collect", {6'd0, p1_ready, p2_ready}, 8'b11);

        @(posedge clock); #1 p1_move = 3'b001; p1_valid = 1'b1;
        @(posedge clock); #1 p1_valid = 1'b0;
`ifdef ROUND_TIMEOUT_EN
        seen = 0;
        for (int k = 0; k < 300 && seen == 0; k++) begin
            @(negedge clock);
            if (round_done) seen = 1;
        end
        chk("tmo_round", {7'd0, round_done}, 8'd1);
        chk("tmo_winner", {6'd0, round_winner}, 8'd1);
`else
        seen = 0;
        repeat (1000) begin
            @(negedge clock);
            if (round_done) seen = 1;
        end
        chk("wait_no_round", seen[7:0], 8'd0);
        chk("wait_ready", {6'd0, p1_ready, p2_ready}, 8'b01);
        chk("wait_judge", {5'd0, judge_p1}, 8'b001);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
